// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the in-order
//   pipeline writeback stage (port P) and a multi-cycle execution unit
//   (port M). P has fixed priority. M is forced through after STARVE_LIMIT
//   consecutive denials. The winning write reaches the register file one
//   cycle after acceptance. Writes to x0 are accepted and then discarded.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   p_valid/p_rd/p_data      pipeline writeback request
//   p_ready                  pipeline request accepted this cycle (comb)
//   m_valid/m_rd/m_data      multi-cycle unit writeback request
//   m_ready                  multi-cycle request accepted this cycle (comb)
//   rf_we/rf_rd/rf_data      registered register-file write port
//   starve_event             forced M grant against a live P request (comb)
//   m_wait_cnt               consecutive M denial count (registered)
module wb_port_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p_valid,
  input  logic [4:0]      p_rd,
  input  logic [XLEN-1:0] p_data,
  output logic            p_ready,
  input  logic            m_valid,
  input  logic [4:0]      m_rd,
  input  logic [XLEN-1:0] m_data,
  output logic            m_ready,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic            starve_event,
  output logic [3:0]      m_wait_cnt
);

  typedef enum logic {
    NORMAL  = 1'b0,
    FORCE_M = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic [3:0]        m_wait_q, m_wait_d;
  logic [4:0]        m_wait_inc;
  logic              m_denied;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]   rf_data_q, rf_data_d;

  // Grant logic. Both readies are held low while reset is asserted so a
  // requester never believes a write was taken during reset.
  always_comb begin
    p_ready      = 1'b0;
    m_ready      = 1'b0;
    starve_event = 1'b0;
    if (!rst) begin
      case (state_q)
        NORMAL: begin
          p_ready = p_valid;
          m_ready = m_valid && !p_valid;
        end
        FORCE_M: begin
          m_ready      = m_valid;
          p_ready      = p_valid && !m_valid;
          starve_event = m_valid && p_valid;
        end
        default: begin
          p_ready = p_valid;
          m_ready = m_valid && !p_valid;
        end
      endcase
    end
  end

  // Denial counter and state transitions. The count is one bit wider
  // before comparison so that a limit of 15 cannot wrap.
  always_comb begin
    m_denied   = m_valid && !m_ready;
    m_wait_inc = {1'b0, m_wait_q} + 5'd1;
    m_wait_d   = 4'd0;
    if (m_denied) begin
      m_wait_d = (m_wait_q >= LIMIT) ? LIMIT : m_wait_inc[3:0];
    end

    state_d = state_q;
    case (state_q)
      NORMAL:  if (m_denied && (m_wait_inc == {1'b0, LIMIT})) state_d = FORCE_M;
      // Leave as soon as M is accepted or withdraws its request.
      FORCE_M: if (!m_denied) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  // Output stage: register the winner; x0 writes complete the handshake
  // but never raise the write enable, and address/data hold otherwise.
  always_comb begin
    rf_we_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (m_ready && (m_rd != 5'd0)) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = m_rd;
      rf_data_d = m_data;
    end else if (p_ready && (p_rd != 5'd0)) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = p_rd;
      rf_data_d = p_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= NORMAL;
      m_wait_q  <= 4'd0;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= 5'd0;
      rf_data_q <= '0;
    end else begin
      state_q   <= state_d;
      m_wait_q  <= m_wait_d;
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_data    = rf_data_q;
  assign m_wait_cnt = m_wait_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  localparam int XLEN  = 64;
  localparam int LIMIT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            p_valid, m_valid;
  logic [4:0]      p_rd, m_rd;
  logic [XLEN-1:0] p_data, m_data;
  logic            p_ready, m_ready, rf_we, starve_event;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_data;
  logic [3:0]      m_wait_cnt;

  wb_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .p_ready(p_ready),
    .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
    .starve_event(starve_event), .m_wait_cnt(m_wait_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t             exp_q[$];
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;
  bit              mon_en = 1'b0;
  logic [4:0]      last_rd = '0;
  logic [XLEN-1:0] last_data = '0;

  // Reference state: pending requests and how many consecutive cycles M
  // has been turned away.
  bit              p_pend, m_pend;
  logic [4:0]      p_rd_v, m_rd_v;
  logic [XLEN-1:0] p_data_v, m_data_v;
  int              denials;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle the write port either shows the next expected
  // write or is idle with address/data holding the last written values.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missed_write_rd", rf_rd, exp_q[0].rd);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("rf_we", {63'd0, rf_we}, 64'd1);
        chk("rf_rd", {59'd0, rf_rd}, {59'd0, e.rd});
        chk("rf_data", rf_data, e.data);
        last_rd   = e.rd;
        last_data = e.data;
      end else begin
        chk("rf_we_idle", {63'd0, rf_we}, 64'd0);
        chk("rf_rd_hold", {59'd0, rf_rd}, {59'd0, last_rd});
        chk("rf_data_hold", rf_data, last_data);
      end
    end
  end

  function automatic logic [4:0] pick_rd(input int zero_pct);
    logic [4:0] r;
    r = ($urandom_range(99) < zero_pct) ? 5'd0 : 5'($urandom_range(31, 1));
    return r;
  endfunction

  // One cycle of stimulus plus prediction of this cycle's grant.
  task automatic step(input int p_pct, input int m_pct, input int zero_pct);
    bit m_wins, p_wins, forced;
    @(negedge clk);
    if (!p_pend && $urandom_range(99) < p_pct) begin
      p_pend = 1'b1; p_rd_v = pick_rd(zero_pct); p_data_v = {$urandom, $urandom};
    end
    if (!m_pend && $urandom_range(99) < m_pct) begin
      m_pend = 1'b1; m_rd_v = pick_rd(zero_pct); m_data_v = {$urandom, $urandom};
    end
    p_valid = p_pend; p_rd = p_rd_v; p_data = p_data_v;
    m_valid = m_pend; m_rd = m_rd_v; m_data = m_data_v;

    // P wins unless M has already waited the full limit.
    forced = (denials >= LIMIT);
    m_wins = m_pend && (forced || !p_pend);
    p_wins = p_pend && !m_wins;

    #1;
    chk("p_ready", {63'd0, p_ready}, {63'd0, p_wins});
    chk("m_ready", {63'd0, m_ready}, {63'd0, m_wins});
    chk("starve_event", {63'd0, starve_event}, {63'd0, forced && p_pend && m_pend});
    chk("m_wait_cnt", {60'd0, m_wait_cnt}, 64'(denials));

    if (m_wins && m_rd_v != 5'd0) exp_q.push_back('{cyc + 1, m_rd_v, m_data_v});
    if (p_wins && p_rd_v != 5'd0) exp_q.push_back('{cyc + 1, p_rd_v, p_data_v});
    if (m_pend && !m_wins) denials = (denials + 1 > LIMIT) ? LIMIT : denials + 1;
    else denials = 0;
    if (m_wins) m_pend = 1'b0;
    if (p_wins) p_pend = 1'b0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    p_pend = 1'b0; m_pend = 1'b0; denials = 0;
    p_rd_v = '0; m_rd_v = '0; p_data_v = '0; m_data_v = '0;
    last_rd = '0; last_data = '0;
  endtask

  task automatic random_phases();
    repeat (40)  step(100, 100, 10);  // starvation under continuous P
    repeat (150) step(50, 50, 15);    // mixed traffic
    repeat (30)  step(100, 0, 0);     // P streaming
    repeat (40)  step(0, 100, 40);    // M only, many x0 targets
    repeat (150) step(70, 40, 10);
  endtask

  initial begin
    int budget;
    clear_model();
    rst = 1'b1;
    p_valid = 1'b1; p_rd = 5'd5; p_data = 64'h55;
    m_valid = 1'b0; m_rd = '0; m_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_rf_we", {63'd0, rf_we}, 64'd0);
    chk("reset_rf_rd", {59'd0, rf_rd}, 64'd0);
    chk("reset_rf_data", rf_data, 64'd0);
    chk("reset_m_wait_cnt", {60'd0, m_wait_cnt}, 64'd0);
    chk("reset_p_ready", {63'd0, p_ready}, 64'd0);
    p_valid = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;

    random_phases();

    // Let outstanding requests finish, then idle so the monitor drains.
    budget = 0;
    while ((p_pend || m_pend) && budget < 50) begin
      step(0, 0, 0);
      budget++;
    end
    if (p_pend || m_pend) begin
      errors++; checks++;
      $display("FAIL drain_timeout pending p=%0d m=%0d", p_pend, m_pend);
    end
    repeat (3) step(0, 0, 0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-cycle just after a write and an M denial.
    @(negedge clk);
    mon_en = 1'b0;
    p_valid = 1'b1; p_rd = 5'd5; p_data = 64'h1234;
    m_valid = 1'b1; m_rd = 5'd9; m_data = 64'hAB;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rf_we", {63'd0, rf_we}, 64'd0);
    chk("async_rf_rd", {59'd0, rf_rd}, 64'd0);
    chk("async_rf_data", rf_data, 64'd0);
    chk("async_m_wait_cnt", {60'd0, m_wait_cnt}, 64'd0);
    chk("async_p_ready", {63'd0, p_ready}, 64'd0);
    chk("async_m_ready", {63'd0, m_ready}, 64'd0);
    @(negedge clk);
    p_valid = 1'b0; m_valid = 1'b0;
    clear_model();
    rst = 1'b0;
    mon_en = 1'b1;

    random_phases();
    repeat (3) step(0, 0, 0);
    while ((p_pend || m_pend) && budget < 100) begin
      step(0, 0, 0);
      budget++;
    end
    repeat (3) step(0, 0, 0);
    chk("final_queue_drained", 64'(exp_q.size()), 64'd0);

    @(negedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
